// File: rtl/sr_input_conditioner_pkg.sv
// Shared types and defaults for the SR latch input conditioner.
package sr_cond_pkg;

  typedef enum logic [1:0] {IDLE, PULSE_S, PULSE_R, GAP} sr_cond_state_t;

  localparam int unsigned DB_CNT_DEF    = 16;
  localparam int unsigned PULSE_LEN_DEF = 1;

endpackage

// File: rtl/sr_input_conditioner_if.sv
// Button inputs and latch-drive outputs of the SR input conditioner.
interface sr_input_conditioner_if;

  logic set_btn;
  logic rst_btn;
  logic s;
  logic r;
  logic busy;
  logic conflict;

  modport master (output set_btn, rst_btn, input s, r, busy, conflict);
  modport slave  (input set_btn, rst_btn, output s, r, busy, conflict);

endinterface

// File: rtl/sr_input_conditioner_debounce.sv
// Per-button 2-flop synchroniser, debounce counter and rising-edge detect.
// The debounce counter exists only when SR_COND_DEBOUNCE_EN is defined.
module sr_debounce
  import sr_cond_pkg::*;
#(
  parameter int unsigned DB_CNT = DB_CNT_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic rise
);

  if (DB_CNT < 2) begin : g_db_cnt_range
    $error("sr_debounce: DB_CNT must be at least 2");
  end

  logic sync1;
  logic sync2;
  logic stable;
  logic stable_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= din;
      sync2 <= sync1;
    end
  end

`ifdef SR_COND_DEBOUNCE_EN
  localparam int unsigned CW = $clog2(DB_CNT + 1);

  logic [CW-1:0] cnt;

  // Accept a new level after DB_CNT consecutive mismatching cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      stable <= 1'b0;
    end else if (sync2 != stable) begin
      if (cnt == CW'(DB_CNT - 1)) begin
        stable <= sync2;
        cnt    <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end else begin
      cnt <= '0;
    end
  end
`else
  assign stable = sync2;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) stable_q <= 1'b0;
    else        stable_q <= stable;
  end

  assign rise = stable & ~stable_q;

endmodule

// File: rtl/sr_input_conditioner.sv
// Turns two raw buttons into mutually exclusive set/reset pulses for an SR latch.
// Debounce filtering is enabled by defining SR_COND_DEBOUNCE_EN.
module sr_input_conditioner
  import sr_cond_pkg::*;
#(
  parameter int unsigned DB_CNT    = DB_CNT_DEF,
  parameter int unsigned PULSE_LEN = PULSE_LEN_DEF
) (
  input  logic                   clk,
  input  logic                   rst_n,
  sr_input_conditioner_if.slave  cond_if
);

  localparam int unsigned PW = (PULSE_LEN > 1) ? $clog2(PULSE_LEN) : 1;

  logic set_req;
  logic rst_req;

  sr_debounce #(.DB_CNT(DB_CNT)) u_db_set (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (cond_if.set_btn),
    .rise  (set_req)
  );

  sr_debounce #(.DB_CNT(DB_CNT)) u_db_rst (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (cond_if.rst_btn),
    .rise  (rst_req)
  );

  sr_cond_state_t state, state_d;
  logic [PW-1:0]  pcnt, pcnt_d;
  logic           set_pend, set_pend_d;
  logic           rst_pend, rst_pend_d;
  logic           s_q, s_d;
  logic           r_q, r_d;
  logic           busy_q, busy_d;
  logic           conflict_q, conflict_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      pcnt       <= '0;
      set_pend   <= 1'b0;
      rst_pend   <= 1'b0;
      s_q        <= 1'b0;
      r_q        <= 1'b0;
      busy_q     <= 1'b0;
      conflict_q <= 1'b0;
    end else begin
      state      <= state_d;
      pcnt       <= pcnt_d;
      set_pend   <= set_pend_d;
      rst_pend   <= rst_pend_d;
      s_q        <= s_d;
      r_q        <= r_d;
      busy_q     <= busy_d;
      conflict_q <= conflict_d;
    end
  end

  // Next state; reset wins over set at IDLE exit and the losing set is dropped.
  always_comb begin
    state_d    = state;
    pcnt_d     = pcnt;
    set_pend_d = set_pend;
    rst_pend_d = rst_pend;
    conflict_d = 1'b0;

    if (state != IDLE) begin
      set_pend_d = set_pend | set_req;
      rst_pend_d = rst_pend | rst_req;
    end

    case (state)
      IDLE: begin
        if (rst_req || rst_pend) begin
          state_d    = PULSE_R;
          pcnt_d     = '0;
          rst_pend_d = 1'b0;
          set_pend_d = 1'b0;
          conflict_d = set_req | set_pend;
        end else if (set_req || set_pend) begin
          state_d    = PULSE_S;
          pcnt_d     = '0;
          set_pend_d = 1'b0;
        end
      end
      PULSE_S, PULSE_R: begin
        if (pcnt == PW'(PULSE_LEN - 1)) state_d = GAP;
        else                            pcnt_d  = pcnt + PW'(1);
      end
      GAP:     state_d = IDLE;
      default: state_d = IDLE;
    endcase

    s_d    = (state_d == PULSE_S);
    r_d    = (state_d == PULSE_R);
    busy_d = (state_d != IDLE);
  end

  assign cond_if.s        = s_q;
  assign cond_if.r        = r_q;
  assign cond_if.busy     = busy_q;
  assign cond_if.conflict = conflict_q;

endmodule

// File: doc/sr_input_conditioner.md
# sr_input_conditioner

Conditions two raw, asynchronous push-button inputs into clean, mutually exclusive set/reset pulses for the downstream cross-coupled NOR SR latch. Each input is synchronised, debounced and edge-detected, and a small pulse FSM drives `s` and `r`. The FSM guarantees that `s` and `r` are never high together, so the latch never sees its forbidden input combination.

## Interface
Parameters:
- `DB_CNT`, default 16: consecutive stable cycles needed to accept a level change. Legal range ≥ 2.
- `PULSE_LEN`, default 1: width of each `s`/`r` pulse in clk cycles. Legal range ≥ 1.

Ports:
- `clk`  in  1  sole clock; all logic on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `set_btn`  in  1  raw set button; asynchronous and may bounce.
- `rst_btn`  in  1  raw reset button; asynchronous and may bounce.
- `s`  out  1  set pulse to the latch; registered.
- `r`  out  1  reset pulse to the latch; registered.
- `busy`  out  1  high while the FSM is not in IDLE.
- `conflict`  out  1  one-cycle flag: a set request was discarded because reset took priority.

## Operation
- **Synchronisation:** each button passes through a 2-flop synchroniser.
- **Debounce, per channel:**
  - A counter of width `$clog2(DB_CNT+1)` increments every cycle the synchronised level differs from the stable level.
  - The counter clears on any cycle where the two levels match.
  - When the counter reaches `DB_CNT` mismatching cycles, the stable level takes the new value and the counter clears.
- **Edge detect:** a 0→1 transition of the stable level raises a request (`set_req` or `rst_req`) for one cycle. A 1→0 transition raises nothing.
- **Pending:** there is one pending bit per channel. A request arriving while `busy` sets its pending bit. A second request to an already-pending channel merges into it and is not queued.
- **FSM states:** IDLE, PULSE_S, PULSE_R, GAP.
  - IDLE → PULSE_R if a reset request or pending reset exists.
  - Otherwise IDLE → PULSE_S if a set request or pending set exists.
  - PULSE_x holds for `PULSE_LEN` cycles, then goes to GAP.
  - GAP lasts 1 cycle with `s` = `r` = 0, then returns to IDLE.
  - The pending bit for a channel clears when its PULSE state is entered.
- **Reset priority:** whenever a reset and a set are both eligible at IDLE exit (fresh, pending, or mixed), the FSM serves reset, discards the set, and pulses `conflict` for 1 cycle.
- **Outputs per state:**
  - `s` = 1 only in PULSE_S.
  - `r` = 1 only in PULSE_R.
  - `busy` = 1 in PULSE_S, PULSE_R and GAP.
- **Invariant:** `s & r` is never 1.

## Timing
- **Reset:** asserting `rst_n` low immediately clears `s`, `r`, `busy`, `conflict`, the synchronisers, counters, stable levels, pending bits and the PULSE counter. The FSM returns to IDLE.
- **Reset mid-pulse:** the pulse is truncated at once. No pulse is emitted on release unless a button is held.
- **Button held through reset:** the stable level resets to 0, so the held button produces one pulse on schedule after `rst_n` rises.
- **Latency:** `s`/`r` rises `DB_CNT`+3 clk edges after the first edge that samples the new steady button level (2 sync, `DB_CNT` debounce, 1 FSM/output register).
- **Bounce shorter than `DB_CNT` cycles:** produces no pulse.
- **Back-to-back service:** minimum spacing between the starts of two pulses is `PULSE_LEN`+2 cycles (pulse, GAP, IDLE).

## Configuration
- **`SR_COND_DEBOUNCE_EN` defined:** debounce counters are present, as described above.
- **`SR_COND_DEBOUNCE_EN` undefined:** counters are removed and the stable level equals the synchroniser output. Latency becomes 3 edges. All FSM, priority and conflict behaviour is unchanged.

## Structure
- **Package `sr_cond_pkg`:**
  - `typedef enum logic [1:0] {IDLE, PULSE_S, PULSE_R, GAP} sr_cond_state_t`.
  - Localparam default values for `DB_CNT` and `PULSE_LEN`.
- **Sub-module `sr_debounce`:** synchroniser + debounce counter (macro-guarded) + rising-edge detect, with parameter `DB_CNT`, ports `clk`, `rst_n`, `din` and `rise`. It is instantiated once per button; the top holds the pending bits and the FSM.

## Test plan
- **Clean set press:** `DB_CNT`=4, `PULSE_LEN`=1; `set_btn` 0→1 and held → `s`=1 for exactly 1 cycle, 7 edges after the first sampling edge; `busy` high for 2 cycles; `r` stays 0.
- **Bounce rejection:** `set_btn` toggles every 2 cycles for 20 cycles, then settles to 0 → no `s` pulse; `busy` stays 0.
- **Simultaneous press:** both buttons rise on the same edge → `r` pulses once, `s` never pulses, `conflict`=1 for 1 cycle.
- **Pending while busy:** `PULSE_LEN`=3; `rst_btn` rise accepted 1 cycle after `s` pulse starts → `s` high 3 cycles, then GAP, IDLE, then `r` high 3 cycles; `s` and `r` never overlap.
- **Reset mid-pulse:** `rst_n` low during the 2nd cycle of a 3-cycle `s` pulse → `s`/`busy` 0 immediately. With `set_btn` still held, exactly one new `s` pulse follows `DB_CNT`+3 edges after `rst_n` release.
- **Macro off:** build without `SR_COND_DEBOUNCE_EN`; steady `set_btn` rise → `s` pulse 3 edges later; a single-cycle glitch lasting ≥ 1 sync cycle also produces a pulse.
